// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the data memory arbiter and its round-robin core.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED0  = 2'd1,
    LOCKED1  = 2'd2
  } lock_st_e;

  localparam int unsigned PORT_LSU = 0;
  localparam int unsigned PORT_DMA = 1;

  localparam logic RSP_ERR_MISALIGNED = 1'b1;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Request/response bundle for both arbiter ports plus the memory-side signals.
interface data_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  p0_valid_i, p0_ready_o, p0_we_i, p0_lock_i;
  logic [ADDR_WIDTH-1:0] p0_addr_i;
  logic [DATA_WIDTH-1:0] p0_wdata_i;
  logic                  p0_rsp_valid_o, p0_rsp_err_o;
  logic                  p1_valid_i, p1_ready_o, p1_we_i, p1_lock_i;
  logic [ADDR_WIDTH-1:0] p1_addr_i;
  logic [DATA_WIDTH-1:0] p1_wdata_i;
  logic                  p1_rsp_valid_o, p1_rsp_err_o;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_read_en_o, mem_write_en_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  p0_valid_i, p0_we_i, p0_lock_i, p0_addr_i, p0_wdata_i,
    input  p1_valid_i, p1_we_i, p1_lock_i, p1_addr_i, p1_wdata_i,
    input  mem_rdata_i,
    output p0_ready_o, p0_rsp_valid_o, p0_rsp_err_o,
    output p1_ready_o, p1_rsp_valid_o, p1_rsp_err_o,
    output rsp_rdata_o, mem_addr_o, mem_wdata_o, mem_read_en_o, mem_write_en_o
  );

  modport master (
    output p0_valid_i, p0_we_i, p0_lock_i, p0_addr_i, p0_wdata_i,
    output p1_valid_i, p1_we_i, p1_lock_i, p1_addr_i, p1_wdata_i,
    output mem_rdata_i,
    input  p0_ready_o, p0_rsp_valid_o, p0_rsp_err_o,
    input  p1_ready_o, p1_rsp_valid_o, p1_rsp_err_o,
    input  rsp_rdata_o, mem_addr_o, mem_wdata_o, mem_read_en_o, mem_write_en_o
  );
endinterface

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-input round-robin grant; i_mask removes ports excluded by the lock state.
module rr_arb2
  import data_mem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] i_req,
  input  logic [1:0] i_mask,
  input  logic       i_ptr_force,
  input  logic       i_ptr_val,
  output logic [1:0] o_gnt
);
  logic       r_ptr;
  logic [1:0] w_req;

  assign w_req = i_req & i_mask;
  assign o_gnt[PORT_LSU] = w_req[PORT_LSU] & (~w_req[PORT_DMA] | ~r_ptr);
  assign o_gnt[PORT_DMA] = w_req[PORT_DMA] & (~w_req[PORT_LSU] |  r_ptr);

  // Pointer names the port that wins the next tie; a grant hands it to the other port.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)          r_ptr <= 1'b0;
    else if (i_ptr_force)  r_ptr <= i_ptr_val;
    else if (|o_gnt)       r_ptr <= o_gnt[PORT_LSU];
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one word memory between LSU (port 0) and DMA (port 1).
// Optional ARB_STATS_EN builds saturating per-port grant counters.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_LOCK_CYCLES = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  data_mem_arbiter_if.slave bus,
  output logic [15:0]       stat_grant0_o,
  output logic [15:0]       stat_grant1_o
);
  localparam int            CW       = $clog2(MAX_LOCK_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_LOCK_CYCLES - 1);

  lock_st_e              r_st;
  logic [CW-1:0]         r_cnt;
  logic [1:0]            r_rsp_vld, r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            w_vld, w_mask, w_gnt;
  logic                  w_locked, w_force, w_any, w_sel, w_we, w_lk, w_mis, w_err;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;

  // Requests are gated by reset so ready and the memory strobes drop immediately.
  assign w_vld    = {bus.p1_valid_i, bus.p0_valid_i} & {2{rst_n_i}};
  assign w_locked = (r_st != UNLOCKED);
  // Last locked cycle: nobody is granted and the lock releases at the coming edge.
  assign w_force  = w_locked && (r_cnt == CNT_LAST);

  always_comb begin
    w_mask = 2'b11;
    if (w_force)              w_mask = 2'b00;
    else if (r_st == LOCKED0) w_mask = 2'b01;
    else if (r_st == LOCKED1) w_mask = 2'b10;
  end

  rr_arb2 u_arb (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .i_req       (w_vld),
    .i_mask      (w_mask),
    .i_ptr_force (w_force),
    .i_ptr_val   (r_st == LOCKED0),
    .o_gnt       (w_gnt)
  );

  assign w_any   = |w_gnt;
  assign w_sel   = w_gnt[PORT_DMA];
  assign w_we    = w_sel ? bus.p1_we_i    : bus.p0_we_i;
  assign w_lk    = w_sel ? bus.p1_lock_i  : bus.p0_lock_i;
  assign w_addr  = w_sel ? bus.p1_addr_i  : bus.p0_addr_i;
  assign w_wdata = w_sel ? bus.p1_wdata_i : bus.p0_wdata_i;
  assign w_mis   = is_misaligned(w_addr[1:0]);
  assign w_err   = w_mis ? RSP_ERR_MISALIGNED : ~RSP_ERR_MISALIGNED;

  assign bus.p0_ready_o     = w_gnt[PORT_LSU];
  assign bus.p1_ready_o     = w_gnt[PORT_DMA];
  assign bus.mem_addr_o     = w_any ? w_addr  : '0;
  assign bus.mem_wdata_o    = w_any ? w_wdata : '0;
  assign bus.mem_write_en_o = w_any &  w_we & ~w_mis;
  assign bus.mem_read_en_o  = w_any & ~w_we & ~w_mis;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_st  <= UNLOCKED;
      r_cnt <= '0;
    end else if (!w_locked) begin
      if (w_any && w_lk) begin
        r_st  <= w_sel ? LOCKED1 : LOCKED0;
        r_cnt <= CW'(1);
      end
    end else if (w_force || (w_any && !w_lk)) begin
      r_st  <= UNLOCKED;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rsp_vld <= '0;
      r_rsp_err <= '0;
      r_rdata   <= '0;
    end else begin
      r_rsp_vld <= w_gnt;
      r_rsp_err <= w_gnt & {2{w_err}};
      if (w_any) r_rdata <= (w_we || w_mis) ? '0 : bus.mem_rdata_i;
    end
  end

  assign bus.p0_rsp_valid_o = r_rsp_vld[PORT_LSU];
  assign bus.p1_rsp_valid_o = r_rsp_vld[PORT_DMA];
  assign bus.p0_rsp_err_o   = r_rsp_err[PORT_LSU];
  assign bus.p1_rsp_err_o   = r_rsp_err[PORT_DMA];
  assign bus.rsp_rdata_o    = r_rdata;

`ifdef ARB_STATS_EN
  logic [1:0][15:0] r_stat;
  for (genvar p = 0; p < 2; p++) begin : g_stat
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)                           r_stat[p] <= '0;
      else if (w_gnt[p] && ~&r_stat[p])       r_stat[p] <= r_stat[p] + 16'd1;
    end
  end
  assign stat_grant0_o = r_stat[PORT_LSU];
  assign stat_grant1_o = r_stat[PORT_DMA];
`else
  assign stat_grant0_o = '0;
  assign stat_grant1_o = '0;
`endif
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized + directed bench for data_mem_arbiter against a transaction-level model.
module tb_data_mem_arbiter;
  localparam int AW = 32, DW = 32, MAXL = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] stat0, stat1;
  int          n_chk = 0, n_err = 0;

  data_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  data_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK_CYCLES(MAXL)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus),
    .stat_grant0_o(stat0), .stat_grant1_o(stat1)
  );

  always #5 clk = ~clk;

  // Memory device (driven by DUT) and golden copy (updated only by the model).
  logic [31:0] dev_mem [64];
  logic [31:0] gold    [64];
  always @(posedge clk) if (bus.mem_write_en_o) dev_mem[bus.mem_addr_o[7:2]] <= bus.mem_wdata_o;
  assign bus.mem_rdata_i = dev_mem[bus.mem_addr_o[7:2]];

  // Model state
  int          ptr, owner, age, dut_g;
  int          n_gnt [2];
  bit          exp_rv [2];
  bit          exp_er [2];
  logic [31:0] exp_rdata;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic reset_model();
    ptr = 0; owner = -1; age = 0;
    n_gnt[0] = 0; n_gnt[1] = 0;
    exp_rv[0] = 0; exp_rv[1] = 0; exp_er[0] = 0; exp_er[1] = 0;
    exp_rdata = '0;
  endtask

  task automatic set_req(input int p, input bit v, input bit we, input bit lk,
                         input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      bus.p0_valid_i = v; bus.p0_we_i = we; bus.p0_lock_i = lk; bus.p0_addr_i = a; bus.p0_wdata_i = d;
    end else begin
      bus.p1_valid_i = v; bus.p1_we_i = we; bus.p1_lock_i = lk; bus.p1_addr_i = a; bus.p1_wdata_i = d;
    end
  endtask

  task automatic idle();
    set_req(0, 0, 0, 0, '0, '0);
    set_req(1, 0, 0, 0, '0, '0);
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 63)) << 2;
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  // One clock: check the previous response and this cycle's grant, then advance the model.
  task automatic tick();
    int g;
    bit v0, v1, we, lk, mis;
    logic [31:0] a, d;
    @(negedge clk);
    chk("p0_rsp_valid", 32'(bus.p0_rsp_valid_o), 32'(exp_rv[0]));
    chk("p1_rsp_valid", 32'(bus.p1_rsp_valid_o), 32'(exp_rv[1]));
    chk("p0_rsp_err",   32'(bus.p0_rsp_err_o),   32'(exp_er[0]));
    chk("p1_rsp_err",   32'(bus.p1_rsp_err_o),   32'(exp_er[1]));
    chk("rsp_rdata",    bus.rsp_rdata_o,         exp_rdata);
    v0 = bus.p0_valid_i; v1 = bus.p1_valid_i;
    g = -1;
    if (owner < 0) begin
      if (v0 && v1) g = ptr;
      else if (v0)  g = 0;
      else if (v1)  g = 1;
    end else if (age < MAXL - 1 && (owner == 0 ? v0 : v1)) begin
      g = owner;
    end
    dut_g = bus.p1_ready_o ? 1 : (bus.p0_ready_o ? 0 : -1);
    chk("p0_ready", 32'(bus.p0_ready_o), 32'(g == 0));
    chk("p1_ready", 32'(bus.p1_ready_o), 32'(g == 1));
    we = (g == 1) ? bus.p1_we_i   : bus.p0_we_i;
    lk = (g == 1) ? bus.p1_lock_i : bus.p0_lock_i;
    a  = (g == 1) ? bus.p1_addr_i : bus.p0_addr_i;
    d  = (g == 1) ? bus.p1_wdata_i : bus.p0_wdata_i;
    mis = (a[1:0] != 2'b00);
    chk("mem_read_en",  32'(bus.mem_read_en_o),  32'(g >= 0 && !we && !mis));
    chk("mem_write_en", 32'(bus.mem_write_en_o), 32'(g >= 0 &&  we && !mis));
    chk("mem_addr",     bus.mem_addr_o,  (g >= 0) ? a : 32'h0);
    chk("mem_wdata",    bus.mem_wdata_o, (g >= 0) ? d : 32'h0);
    exp_rv[0] = 0; exp_rv[1] = 0; exp_er[0] = 0; exp_er[1] = 0;
    if (g >= 0) begin
      exp_rv[g] = 1;
      exp_er[g] = mis;
      exp_rdata = (we || mis) ? 32'h0 : gold[a[7:2]];
      if (we && !mis) gold[a[7:2]] = d;
      n_gnt[g]++;
      ptr = 1 - g;
    end
    if (owner >= 0) begin
      if (age == MAXL - 1) begin ptr = 1 - owner; owner = -1; age = 0; end
      else if (g == owner && !lk) begin owner = -1; age = 0; end
      else age++;
    end else if (g >= 0 && lk) begin
      owner = g; age = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rdy0"}, 32'(bus.p0_ready_o), 0);
    chk({tag, "_rdy1"}, 32'(bus.p1_ready_o), 0);
    chk({tag, "_rv0"},  32'(bus.p0_rsp_valid_o), 0);
    chk({tag, "_rv1"},  32'(bus.p1_rsp_valid_o), 0);
    chk({tag, "_err"},  32'({bus.p0_rsp_err_o, bus.p1_rsp_err_o}), 0);
    chk({tag, "_rdata"}, bus.rsp_rdata_o, 0);
    chk({tag, "_men"},  32'({bus.mem_read_en_o, bus.mem_write_en_o}), 0);
    chk({tag, "_maddr"}, bus.mem_addr_o, 0);
    chk({tag, "_stat"}, {stat0, stat1}, 0);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 64; i++) begin gold[i] = $urandom; dev_mem[i] = gold[i]; end
    gold[4] = 32'hDEADBEEF; dev_mem[4] = 32'hDEADBEEF;
    reset_model();
    // Requests held valid during reset must not be accepted.
    set_req(0, 1, 0, 0, 32'h10, 0);
    set_req(1, 1, 1, 0, 32'h20, 32'h1);
    #12;
    chk_idle_outputs("reset");
    idle();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Contention: both ports valid 4 cycles -> 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1, 0, 0, rnd_addr() & ~32'h3, 0);
      set_req(1, 1, 0, 0, rnd_addr() & ~32'h3, 0);
      tick();
      chk("contend_gnt", 32'(dut_g), 32'(i % 2));
    end
    idle(); tick();

    // Single aligned read
    set_req(0, 1, 0, 0, 32'h10, 0);
    tick();
    idle();
    chk("single_rdata", bus.rsp_rdata_o, 32'hDEADBEEF);
    tick();

    // Misaligned write: accepted, no memory write, error response
    set_req(1, 1, 1, 0, 32'h13, 32'h55);
    tick();
    idle();
    chk("misal_err", 32'(bus.p1_rsp_err_o), 1);
    tick();
    set_req(0, 1, 0, 0, 32'h10, 0);
    tick();
    idle();
    chk("misal_unchanged", bus.rsp_rdata_o, 32'hDEADBEEF);
    tick();

    // Locked read-modify-write on port 0 with port 1 waiting
    set_req(0, 1, 0, 1, 32'h20, 0);
    tick();
    set_req(0, 1, 1, 0, 32'h20, 32'hCAFE0001);
    set_req(1, 1, 0, 0, 32'h20, 0);
    tick();
    chk("rmw_p0_gnt", 32'(dut_g), 0);
    set_req(0, 0, 0, 0, 0, 0);
    tick();
    chk("rmw_p1_after", 32'(dut_g), 1);
    idle();
    chk("rmw_rdata", bus.rsp_rdata_o, 32'hCAFE0001);
    tick();

    // Forced release: p0 locks then goes idle, p1 waits
    set_req(0, 1, 0, 1, 32'h30, 0);
    tick();
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 1, 0, 0, 32'h34, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dut_g == 1) break;
      cnt++;
    end
    chk("force_wait", 32'(cnt), 32'(MAXL - 1));
    idle(); tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++)
        set_req(p, $urandom_range(0, 99) < 65, $urandom_range(0, 1) == 1,
                $urandom_range(0, 99) < 20, rnd_addr(), $urandom);
      tick();
    end

    // Reset in LOCKED1 with a response pending
    idle();
    for (int i = 0; i < MAXL + 2; i++) tick();
    set_req(1, 1, 0, 1, 32'h40, 0);
    tick();
    chk("pre_rst_rv1", 32'(bus.p1_rsp_valid_o), 1);
    set_req(0, 1, 0, 0, 32'h44, 0);
    #1 rst_n = 1'b0;
    #1;
    chk_idle_outputs("midlock_rst");
    idle();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    reset_model();
    chk("post_rst_stat0", 32'(stat0), 0);
    set_req(0, 1, 0, 0, 32'h10, 0);
    set_req(1, 1, 0, 0, 32'h14, 0);
    tick();
    chk("post_rst_gnt", 32'(dut_g), 0);
    for (int i = 0; i < 200; i++) begin
      for (int p = 0; p < 2; p++)
        set_req(p, $urandom_range(0, 99) < 70, $urandom_range(0, 1) == 1,
                $urandom_range(0, 99) < 15, rnd_addr(), $urandom);
      tick();
    end
    idle(); tick();

`ifdef ARB_STATS_EN
    chk("stat0", 32'(stat0), 32'(n_gnt[0]));
    chk("stat1", 32'(stat1), 32'(n_gnt[1]));
`else
    chk("stat0", 32'(stat0), 0);
    chk("stat1", 32'(stat1), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
